// File: rtl/wave_table_player_pkg.sv
// Shared constants and helpers for the wave table player and its bench.
package wave_table_player_pkg;

  // Issue -> aso_valid latency: one cycle RAM read, one cycle output register.
  localparam int PIPE_LAT = 2;

  // Byte-enable width for a given data width (data width is a multiple of 8).
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/wave_ram_dp.sv
// True dual-port waveform RAM: port A byte-masked read/write for the CPU,
// port B clock-enabled read for the playback engine. Reads return old data
// when the other port writes the same address in the same cycle.
module wave_ram_dp
  import wave_table_player_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic [ADDR_W-1:0]       addr_a,
  input  logic                    we_a,
  input  logic [DATA_W/8-1:0]     be_a,
  input  logic [DATA_W-1:0]       wdata_a,
  output logic [DATA_W-1:0]       q_a,
  input  logic [ADDR_W-1:0]       addr_b,
  input  logic                    clken_b,
  output logic [DATA_W-1:0]       q_b
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  // Stored as byte lanes so the write mask maps directly onto lanes.
  // The init file is handed to the vendor RAM inference through the attribute.
  (* ram_init_file = INIT_FILE *)
  logic [BE_W-1:0][7:0] mem [DEPTH];

  logic [BE_W-1:0][7:0] wlanes;
  assign wlanes = wdata_a;

  // Port A: byte-masked write, registered read (read-before-write).
  always_ff @(posedge clk) begin
    if (we_a) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_a[b]) mem[addr_a][b] <= wlanes[b];
      end
    end
    q_a <= mem[addr_a];
  end

  // Port B: registered read, frozen while the stream is stalled.
  always_ff @(posedge clk) begin
    if (clken_b) q_b <= mem[addr_b];
  end

endmodule

// File: rtl/wave_table_player.sv
// Waveform table with CPU load/readback port and an NCO-driven streaming
// source with backpressure.
module wave_table_player
  import wave_table_player_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 8,
  parameter int    PHASE_W   = 32,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     avs_address,
  input  logic                  avs_chipselect,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DATA_W/8-1:0]   avs_byteenable,
  input  logic [DATA_W-1:0]     avs_writedata,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  avs_readdatavalid,
  input  logic                  play_en,
  input  logic                  phase_clr,
  input  logic [PHASE_W-1:0]    tuning_word,
  output logic [DATA_W-1:0]     aso_data,
  output logic                  aso_valid,
  input  logic                  aso_ready,
  output logic                  wrap_pulse
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W:0]   phase_sum;
  logic [PIPE_LAT:1]  vld_pipe;      // [1] = RAM read in flight, [PIPE_LAT] = aso_valid
  logic               stall;
  logic               issue;
  logic               cpu_wr;
  logic               cpu_rd;
  logic               rd_vld;
  logic [DATA_W-1:0]  q_a;
  logic [DATA_W-1:0]  q_b;

  // Handshake decode and phase increment with carry-out for wrap detection.
  always_comb begin
    stall     = vld_pipe[PIPE_LAT] & ~aso_ready;
    issue     = play_en & ~stall & ~phase_clr;
    phase_sum = {1'b0, phase} + {1'b0, tuning_word};
    cpu_wr    = avs_chipselect & avs_write;
    cpu_rd    = avs_chipselect & avs_read & ~avs_write;
  end

  wave_ram_dp #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .addr_a  (avs_address),
    .we_a    (cpu_wr),
    .be_a    (avs_byteenable),
    .wdata_a (avs_writedata),
    .q_a     (q_a),
    .addr_b  (phase[PHASE_W-1 -: ADDR_W]),
    .clken_b (~stall),
    .q_b     (q_b)
  );

  // NCO, valid pipeline and output register; clear beats stall, stall freezes all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase      <= '0;
      vld_pipe   <= '0;
      aso_data   <= '0;
      wrap_pulse <= 1'b0;
    end else if (phase_clr) begin
      phase      <= '0;
      vld_pipe   <= '0;
      wrap_pulse <= 1'b0;
    end else if (!stall) begin
      if (issue) phase <= phase_sum[PHASE_W-1:0];
      vld_pipe   <= {vld_pipe[PIPE_LAT-1:1], issue};
      aso_data   <= q_b;
      wrap_pulse <= issue & phase_sum[PHASE_W];
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

  assign aso_valid = vld_pipe[PIPE_LAT];

  // CPU read data qualifier, one cycle after the read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_vld <= 1'b0;
    else          rd_vld <= cpu_rd;
  end

  // RAM output is not reset, so readdata is held at zero outside a valid beat.
  assign avs_readdatavalid = rd_vld;
  assign avs_readdata      = rd_vld ? q_a : '0;

endmodule

// File: tb/tb_wave_table_player.sv
// Directed bench: CPU byte-masked access vectors plus streaming corner cases.
module tb_wave_table_player;
  import wave_table_player_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 8;
  localparam int PHASE_W = 32;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [ADDR_W-1:0]  avs_address;
  logic               avs_chipselect;
  logic               avs_read;
  logic               avs_write;
  logic [3:0]         avs_byteenable;
  logic [DATA_W-1:0]  avs_writedata;
  logic [DATA_W-1:0]  avs_readdata;
  logic               avs_readdatavalid;
  logic               play_en;
  logic               phase_clr;
  logic [PHASE_W-1:0] tuning_word;
  logic [DATA_W-1:0]  aso_data;
  logic               aso_valid;
  logic               aso_ready;
  logic               wrap_pulse;

  int checks = 0;
  int errors = 0;

  wave_table_player #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PHASE_W(PHASE_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_chipselect(avs_chipselect),
    .avs_read(avs_read), .avs_write(avs_write),
    .avs_byteenable(avs_byteenable), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .play_en(play_en), .phase_clr(phase_clr), .tuning_word(tuning_word),
    .aso_data(aso_data), .aso_valid(aso_valid), .aso_ready(aso_ready),
    .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } cpu_vec_t;

  cpu_vec_t vecs[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    avs_chipselect = 1'b1; avs_write = 1'b1;
    avs_address = a; avs_byteenable = be; avs_writedata = d;
    tick;
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
    chk({nm, " rdv_before"}, {31'b0, avs_readdatavalid}, 32'd0);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    tick;
    avs_chipselect = 1'b0; avs_read = 1'b0;
    chk({nm, " rdv"}, {31'b0, avs_readdatavalid}, 32'd1);
    chk({nm, " data"}, avs_readdata, exp);
    tick;
    chk({nm, " rdv_after"}, {31'b0, avs_readdatavalid}, 32'd0);
  endtask

  task automatic pulse_clr;
    phase_clr = 1'b1;
    tick;
    phase_clr = 1'b0;
  endtask

  task automatic chk_stream(input string nm, input logic [31:0] exp);
    chk({nm, " valid"}, {31'b0, aso_valid}, 32'd1);
    chk({nm, " data"}, aso_data, exp);
  endtask

  initial begin
    vecs[0] = '{8'h10, 4'b0011, 32'hA5A5_5A5A, 32'h0000_5A5A};
    vecs[1] = '{8'h10, 4'b1100, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
    vecs[2] = '{8'h20, 4'b0100, 32'h1234_5678, 32'h0034_0020};
    vecs[3] = '{8'h30, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0030};
    vecs[4] = '{8'hFF, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5] = '{8'h00, 4'b1000, 32'hCAFE_0000, 32'hCA00_0000};

    reset_n = 1'b0;
    avs_address = '0; avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    avs_byteenable = '0; avs_writedata = '0;
    play_en = 1'b0; phase_clr = 1'b0; tuning_word = 32'h0100_0000;
    aso_ready = 1'b1;
    #12;
    chk("reset aso_valid", {31'b0, aso_valid}, 32'd0);
    chk("reset aso_data", aso_data, 32'd0);
    chk("reset readdata", avs_readdata, 32'd0);
    chk("reset rdv", {31'b0, avs_readdatavalid}, 32'd0);
    chk("reset wrap", {31'b0, wrap_pulse}, 32'd0);
    reset_n = 1'b1;
    tick;

    // Table[i] = i, then byte-masked write/readback vectors.
    for (int i = 0; i < 256; i++) cpu_write(i[7:0], 4'hF, i);
    for (int v = 0; v < 6; v++) begin
      cpu_write(vecs[v].addr, vecs[v].be, vecs[v].wdata);
      cpu_read(vecs[v].addr, vecs[v].exp, $sformatf("cpu vec%0d", v));
    end
    for (int i = 0; i < 256; i++) cpu_write(i[7:0], 4'hF, i);

    // Continuous stream with wrap.
    play_en = 1'b1;
    tick;
    chk("stream first cycle idle", {31'b0, aso_valid}, 32'd0);
    for (int n = PIPE_LAT; n <= 262; n++) begin
      tick;
      chk_stream($sformatf("stream k=%0d", n - PIPE_LAT), (n - PIPE_LAT) % 256);
      chk($sformatf("wrap k=%0d", n - PIPE_LAT), {31'b0, wrap_pulse},
          {31'b0, ((n - PIPE_LAT) % 256) == 254});
    end
    play_en = 1'b0;
    tick;
    chk_stream("drain last issued", 32'd5);
    chk("drain wrap", {31'b0, wrap_pulse}, 32'd0);
    tick;
    chk("drain idle", {31'b0, aso_valid}, 32'd0);

    // Backpressure at sample 7.
    pulse_clr;
    play_en = 1'b1;
    tick;
    for (int k = 0; k <= 7; k++) begin
      tick;
      chk_stream($sformatf("bp k=%0d", k), k);
    end
    aso_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick;
      chk_stream($sformatf("bp hold%0d", s), 32'd7);
      chk("bp wrap", {31'b0, wrap_pulse}, 32'd0);
    end
    aso_ready = 1'b1;
    for (int k = 8; k <= 15; k++) begin
      tick;
      chk_stream($sformatf("bp k=%0d", k), k);
    end

    // phase_clr during a stall.
    aso_ready = 1'b0;
    tick;
    chk_stream("clr pre-stall", 32'd15);
    phase_clr = 1'b1;
    tick;
    chk("clr valid drop", {31'b0, aso_valid}, 32'd0);
    phase_clr = 1'b0;
    aso_ready = 1'b1;
    tick;
    chk("clr refill", {31'b0, aso_valid}, 32'd0);
    tick;
    chk_stream("clr first", 32'd0);
    tick;
    chk_stream("clr second", 32'd1);

    // CPU write to the address port B reads in the same cycle.
    pulse_clr;
    for (int n = 1; n <= 270; n++) begin
      if (n == 6) begin
        avs_chipselect = 1'b1; avs_write = 1'b1;
        avs_address = 8'd5; avs_byteenable = 4'hF; avs_writedata = 32'h55AA_00FF;
      end
      tick;
      if (n == 6) begin
        avs_chipselect = 1'b0; avs_write = 1'b0;
      end
      if (n >= PIPE_LAT) begin
        int k;
        logic [31:0] e;
        k = n - PIPE_LAT;
        e = (k == 261) ? 32'h55AA_00FF : k % 256;
        chk_stream($sformatf("coll k=%0d", k), e);
      end
    end
    play_en = 1'b0;
    tick;
    tick;

    // Reset mid-stream.
    cpu_write(8'd0, 4'hF, 32'h0BAD_F00D);
    pulse_clr;
    play_en = 1'b1;
    tick;
    tick;
    chk_stream("rst pre0", 32'h0BAD_F00D);
    tick;
    chk_stream("rst pre1", 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst async valid", {31'b0, aso_valid}, 32'd0);
    chk("rst async data", aso_data, 32'd0);
    chk("rst async wrap", {31'b0, wrap_pulse}, 32'd0);
    chk("rst async rdv", {31'b0, avs_readdatavalid}, 32'd0);
    chk("rst async readdata", avs_readdata, 32'd0);
    tick;
    chk("rst held valid", {31'b0, aso_valid}, 32'd0);
    reset_n = 1'b1;
    tick;
    chk("rst refill", {31'b0, aso_valid}, 32'd0);
    tick;
    chk_stream("rst first", 32'h0BAD_F00D);
    tick;
    chk_stream("rst second", 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
